pipelined_addsub: RTL and testbench

//  Parametrised pipelined ripple-carry adder/subtractor, successor to the 4-bit ripple adder.

---
 rtl/addsub_pkg.sv | 12 +
 rtl/full_adder_bit.sv | 13 +
 rtl/pipelined_addsub.sv | 120 ++++++++++++
 tb/tb_pipelined_addsub.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared constants and width helpers for the pipelined adder/subtractor.
package addsub_pkg;

  localparam logic ADDSUB_OP_ADD = 1'b0;
  localparam logic ADDSUB_OP_SUB = 1'b1;

  // Bits resolved per pipeline stage; falls back to WIDTH when STAGES is invalid.
  function automatic int chunk_width(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder cell; chained within a stage to ripple one chunk.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage, carry
// registered between stages, valid/ready handshake with global stall.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES (STAGES >= 1)");
  end

  logic en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    // Operand bits not yet consumed: chunk k sits at the bottom of a_d/b_d.
    localparam int IN_W = WIDTH - k * CHUNK;

    logic [IN_W-1:0]          a_d;
    logic [IN_W-1:0]          b_d;
    logic                     c_d;
    logic                     v_d;
    logic [CHUNK:0]           rc;
    logic [CHUNK-1:0]         chunk_sum;
    logic [(k+1)*CHUNK-1:0]   s_next;
    logic                     v_q;
    logic [(k+1)*CHUNK-1:0]   s_q;

    if (k == 0) begin : g_src_in
      assign a_d    = A;
      assign b_d    = (sub == ADDSUB_OP_SUB) ? ~B : B;
      assign c_d    = (sub == ADDSUB_OP_SUB) ? 1'b1 : cin;
      assign v_d    = in_valid;
      assign s_next = chunk_sum;
    end else begin : g_src_prev
      assign a_d    = stg[k-1].g_skew.a_q;
      assign b_d    = stg[k-1].g_skew.b_q;
      assign c_d    = stg[k-1].g_skew.c_q;
      assign v_d    = stg[k-1].v_q;
      assign s_next = {chunk_sum, stg[k-1].s_q};
    end

    assign rc[0] = c_d;
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      full_adder_bit u_fa (
        .a  (a_d[i]),
        .b  (b_d[i]),
        .c  (rc[i]),
        .s  (chunk_sum[i]),
        .co (rc[i+1])
      );
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        v_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_d;
        s_q <= s_next;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [IN_W-CHUNK-1:0] a_q;
      logic [IN_W-CHUNK-1:0] b_q;
      logic                  c_q;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (en) begin
          a_q <= a_d[IN_W-1:CHUNK];
          b_q <= b_d[IN_W-1:CHUNK];
          c_q <= rc[CHUNK];
        end
      end
    end else begin : g_flags
      // Final stage holds the MSB chunk, so A'/B' sign bits are still at hand here.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          cout <= 1'b0;
          ovf  <= 1'b0;
          zero <= 1'b0;
        end else if (en) begin
          cout <= rc[CHUNK];
          ovf  <= (a_d[IN_W-1] == b_d[IN_W-1]) && (s_next[WIDTH-1] != a_d[IN_W-1]);
          zero <= (s_next == '0);
        end
      end
    end
  end

  assign out_valid = stg[STAGES-1].v_q;
  assign S         = stg[STAGES-1].s_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed self-checking bench for pipelined_addsub (WIDTH=16, STAGES=4).
module tb_pipelined_addsub;
  import addsub_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] S;
  logic        cout;
  logic        ovf;
  logic        zero;

  int total = 0;
  int bad   = 0;

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result packed as {ovf, zero, cout, S}.
  function automatic logic [18:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                         input logic ci, input logic sb);
    logic [15:0] bp;
    logic [16:0] sum;
    logic        o;
    bp  = sb ? ~b : b;
    sum = {1'b0, a} + {1'b0, bp} + {16'd0, (sb ? 1'b1 : ci)};
    o   = (a[15] == bp[15]) && (sum[15] != a[15]);
    return {o, (sum[15:0] == 16'h0000), sum[16], sum[15:0]};
  endfunction

  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sb, input logic [15:0] es,
                         input logic ec, input logic eo, input logic ez);
    @(negedge clock);
    A = a; B = b; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_early"}, 32'(out_valid), 32'd0);
      @(negedge clock);
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_S"},     32'(S),         32'(es));
    chk({tag, "_cout"},  32'(cout),      32'(ec));
    chk({tag, "_ovf"},   32'(ovf),       32'(eo));
    chk({tag, "_zero"},  32'(zero),      32'(ez));
  endtask

  logic [15:0] va  [8] = '{16'h0001, 16'hABCD, 16'h8000, 16'h00FF,
                           16'h1000, 16'h7FFF, 16'hFFFF, 16'h0F0F};
  logic [15:0] vb  [8] = '{16'h0002, 16'h1234, 16'h8000, 16'h0F01,
                           16'h1000, 16'hFFFF, 16'hFFFF, 16'hF0F0};
  logic        vci [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        vsb [8] = '{ADDSUB_OP_ADD, ADDSUB_OP_SUB, ADDSUB_OP_ADD, ADDSUB_OP_ADD,
                           ADDSUB_OP_SUB, ADDSUB_OP_SUB, ADDSUB_OP_ADD, ADDSUB_OP_SUB};

  initial begin
    logic [18:0] q[$];
    logic [18:0] exp_r;
    logic [15:0] held;
    int idx;
    int got;
    int stale;

    // Step 1: reset
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_S",         32'(S),         32'h0000);
    chk("rst_cout",      32'(cout),      32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    chk("rst_zero",      32'(zero),      32'd0);

    // Steps 2-4: directed vectors
    run_one("add_basic",  16'h1234, 16'h1111, 1'b0, ADDSUB_OP_ADD, 16'h2345, 1'b0, 1'b0, 1'b0);
    run_one("add_wrap",   16'hFFFF, 16'h0001, 1'b0, ADDSUB_OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_one("add_ovf",    16'h7FFF, 16'h0001, 1'b0, ADDSUB_OP_ADD, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_one("add_cin",    16'h0001, 16'h0002, 1'b1, ADDSUB_OP_ADD, 16'h0004, 1'b0, 1'b0, 1'b0);
    run_one("sub_borrow", 16'h0005, 16'h0007, 1'b0, ADDSUB_OP_SUB, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_one("sub_ovf",    16'h8000, 16'h0001, 1'b0, ADDSUB_OP_SUB, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_one("sub_cin1",   16'h0005, 16'h0007, 1'b1, ADDSUB_OP_SUB, 16'hFFFE, 1'b0, 1'b0, 1'b0);

    // Step 5: back-to-back stream with out_ready low on cycles 5..7
    @(negedge clock);
    idx = 0;
    got = 0;
    held = '0;
    for (int c = 1; c <= 40 && got < 8; c++) begin
      out_ready = !(c >= 5 && c <= 7);
      if (idx < 8) begin
        A = va[idx]; B = vb[idx]; cin = vci[idx]; sub = vsb[idx]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("strm_in_ready", 32'(in_ready), 32'(!(c >= 5 && c <= 7)));
      if (c == 5) held = S;
      if (c == 6 || c == 7) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_S",     32'(S),         32'(held));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("strm_spurious", 32'(out_valid), 32'd0);
        end else begin
          exp_r = q.pop_front();
          chk("strm_S",    32'(S),    32'(exp_r[15:0]));
          chk("strm_cout", 32'(cout), 32'(exp_r[16]));
          chk("strm_zero", 32'(zero), 32'(exp_r[17]));
          chk("strm_ovf",  32'(ovf),  32'(exp_r[18]));
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_op(va[idx], vb[idx], vci[idx], vsb[idx]));
        idx++;
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("strm_count", 32'(got), 32'd8);

    // Step 6: asynchronous reset with three ops in flight
    @(negedge clock);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A = 16'h1111 * 16'(i + 1); B = 16'h0101; cin = 1'b0; sub = ADDSUB_OP_ADD; in_valid = 1'b1;
      @(negedge clock);
    end
    in_valid = 1'b0;
    @(negedge clock);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_ready", 32'(in_ready),  32'd1);
    chk("async_rst_S",     32'(S),         32'h0000);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clock);
      if (out_valid) stale++;
    end
    chk("no_stale", 32'(stale), 32'd0);
    run_one("post_rst", 16'h4321, 16'h1234, 1'b0, ADDSUB_OP_SUB, 16'h30ED, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
